// File: rtl/send_scheduler_if.sv
// Bundle between the two pixel-buffer requesters, the send scheduler and the pixel/control output FIFOs.
interface send_scheduler_if #(
    parameter int BUFF_SIZE_BIT = 6
);
    logic                     req0;
    logic                     req1;
    logic [BUFF_SIZE_BIT-1:0] size0;
    logic [BUFF_SIZE_BIT-1:0] size1;
    logic                     px_full;
    logic                     ctrl_full;
    logic                     gnt0;
    logic                     gnt1;
    logic                     sel;
    logic [BUFF_SIZE_BIT-1:0] rd_addr;
    logic                     px_wr;
    logic                     ctrl_wr;
    logic                     busy;
    logic                     done;

    // master = requesters and FIFO status side, slave = the scheduler itself
    modport master (
        output req0, req1, size0, size1, px_full, ctrl_full,
        input  gnt0, gnt1, sel, rd_addr, px_wr, ctrl_wr, busy, done
    );

    modport slave (
        input  req0, req1, size0, size1, px_full, ctrl_full,
        output gnt0, gnt1, sel, rd_addr, px_wr, ctrl_wr, busy, done
    );
endinterface

// File: rtl/send_scheduler.sv
// Round-robin scheduler streaming one of two pixel buffers into the pixel FIFO, with one control burst per transfer.
module send_scheduler #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
    input logic             clk,
    input logic             rst,
    send_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [BUFF_SIZE_BIT-1:0] MAX_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);
    localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);

    state_e                   state_q, state_d;
    logic [BUFF_SIZE_BIT-1:0] count_q, count_d;
    logic [BUFF_SIZE_BIT-1:0] size_q, size_d;
    logic                     sel_q, sel_d;
    logic                     rr_q, rr_d;
    logic                     gnt0_q, gnt0_d;
    logic                     gnt1_q, gnt1_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     pick1;
    logic [BUFF_SIZE_BIT-1:0] req_size;
    logic [BUFF_SIZE_BIT-1:0] clamped;
    logic                     px_wr;
    logic                     ctrl_wr;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        size_d   = size_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        px_wr    = 1'b0;
        ctrl_wr  = 1'b0;

        // rr only breaks ties; a lone requester always wins
        pick1    = bus.req1 & (~bus.req0 | rr_q);
        req_size = pick1 ? bus.size1 : bus.size0;
        clamped  = (req_size > MAX_SIZE) ? MAX_SIZE : req_size;

        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    sel_d   = pick1;
                    size_d  = clamped;
                    count_d = '0;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    busy_d  = 1'b1;
                    if (clamped != '0) begin
                        state_d = SEND;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                // the control words ride on the first pixel beat, so both FIFOs must have room
                if (count_q == '0) begin
                    px_wr   = ~bus.px_full & ~bus.ctrl_full;
                    ctrl_wr = px_wr;
                end else begin
                    px_wr   = ~bus.px_full;
                end
                if (px_wr) begin
                    if (count_q == size_q - ONE) begin
                        count_d = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            end
            DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                rr_d    = ~sel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            px_wr   = 1'b0;
            ctrl_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            size_q  <= '0;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.sel     = sel_q;
    assign bus.rd_addr = count_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.px_wr   = px_wr;
    assign bus.ctrl_wr = ctrl_wr;
endmodule

// File: tb/tb_send_scheduler.sv
// Bench for send_scheduler: vector table, directed corner sequences and a randomized run against a transfer-level model.
module tb_send_scheduler;
    localparam int BUFF_SIZE = 32;
    localparam int SW        = $clog2(BUFF_SIZE) + 1;
    localparam int OUT_W     = 7 + SW;

    typedef enum {M_FREE, M_MOVING, M_FINISH} model_phase_e;

    // ctl = {rst, req0, req1, px_full, ctrl_full}; exp = {gnt0, gnt1, sel, busy, done, px_wr, ctrl_wr}
    typedef struct {
        logic [4:0] ctl;
        int         size0;
        int         size1;
        logic [6:0] exp;
        int         rd;
    } vec_t;

    typedef struct {
        int owner;
        int px;
        int ctrl;
        int last_rd;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    send_scheduler_if #(.BUFF_SIZE_BIT(SW)) bus ();

    send_scheduler #(.BUFF_SIZE(BUFF_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               checks = 0;
    int               errors = 0;
    model_phase_e     m_phase = M_FREE;
    int               m_owner = 0;
    int               m_rr = 0;
    int               m_len = 0;
    int               m_sent = 0;
    int               obs_px = 0;
    int               obs_ctrl = 0;
    int               obs_last_rd = 0;
    int               last_rd_seen = 0;
    logic [OUT_W-1:0] last_vec_seen;
    xfer_t            done_log[$];
    vec_t             vecs[20];

    task automatic check_vec(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] ctl, input int s0, input int s1, input logic [6:0] e, input int rd);
        vec_t v;
        v.ctl   = ctl;
        v.size0 = s0;
        v.size1 = s1;
        v.exp   = e;
        v.rd    = rd;
        return v;
    endfunction

    function automatic int rand_size();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return int'($urandom_range(33, 63));
        return int'($urandom_range(1, 8));
    endfunction

    // Model: a transfer owns the output until len beats have gone, then one finish cycle, then the bus is free.
    function automatic logic model_px();
        return !rst && m_phase == M_MOVING && !bus.px_full && (m_sent > 0 || !bus.ctrl_full);
    endfunction

    function automatic logic [OUT_W-1:0] model_out();
        logic act;
        logic px;
        act = (m_phase != M_FREE);
        px  = model_px();
        return {act && m_owner == 0, act && m_owner == 1, act && m_owner == 1, act,
                m_phase == M_FINISH, px, px && m_sent == 0, SW'(m_sent)};
    endfunction

    function automatic logic [OUT_W-1:0] dut_out(input logic keep_sel);
        return {bus.gnt0, bus.gnt1, bus.sel & keep_sel, bus.busy, bus.done,
                bus.px_wr, bus.ctrl_wr, bus.rd_addr};
    endfunction

    task automatic model_advance();
        logic px;
        int   sz;
        px = model_px();
        if (rst) begin
            m_phase = M_FREE;
            m_owner = 0;
            m_rr    = 0;
            m_len   = 0;
            m_sent  = 0;
        end else begin
            case (m_phase)
                M_FREE: begin
                    if (bus.req0 || bus.req1) begin
                        m_owner = (bus.req0 && bus.req1) ? m_rr : (bus.req1 ? 1 : 0);
                        sz      = (m_owner == 1) ? int'(bus.size1) : int'(bus.size0);
                        m_len   = (sz > BUFF_SIZE) ? BUFF_SIZE : sz;
                        m_sent  = 0;
                        m_phase = (m_len > 0) ? M_MOVING : M_FINISH;
                    end
                end
                M_MOVING: begin
                    if (px) begin
                        m_sent++;
                        if (m_sent == m_len) begin
                            m_sent  = 0;
                            m_phase = M_FINISH;
                        end
                    end
                end
                M_FINISH: begin
                    m_rr    = 1 - m_owner;
                    m_phase = M_FREE;
                end
                default: m_phase = M_FREE;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic [4:0] ctl, input int s0, input int s1);
        rst           = ctl[4];
        bus.req0      = ctl[3];
        bus.req1      = ctl[2];
        bus.px_full   = ctl[1];
        bus.ctrl_full = ctl[0];
        bus.size0     = SW'(s0);
        bus.size1     = SW'(s1);
    endtask

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] m,
                               input logic has_exp, input logic [OUT_W-1:0] tbl);
        check_vec({name, "_model"}, dut_out(m[OUT_W-4]), m);
        if (has_exp) check_vec({name, "_table"}, dut_out(tbl[OUT_W-4]), tbl);
    endtask

    task automatic step(input logic has_exp, input logic [OUT_W-1:0] tbl, input string name);
        logic [OUT_W-1:0] m;
        #1;
        m             = model_out();
        last_vec_seen = dut_out(1'b1);
        last_rd_seen  = int'(bus.rd_addr);
        if (rst) begin
            obs_px   = 0;
            obs_ctrl = 0;
        end else begin
            if (bus.px_wr === 1'b1) begin
                obs_px++;
                obs_last_rd = int'(bus.rd_addr);
            end
            if (bus.ctrl_wr === 1'b1) obs_ctrl++;
            if (bus.done === 1'b1) begin
                done_log.push_back('{int'(bus.gnt1), obs_px, obs_ctrl, obs_last_rd});
                obs_px   = 0;
                obs_ctrl = 0;
            end
        end
        checkOutput(name, m, has_exp, tbl);
        model_advance();
        @(negedge clk);
    endtask

    task automatic run_until_done(input int n, input int limit, input string name);
        int start;
        int cyc;
        start = done_log.size();
        cyc   = 0;
        while (done_log.size() - start < n && cyc < limit) begin
            step(1'b0, '0, name);
            cyc++;
        end
        check_int({name, "_done_count"}, done_log.size() - start, n);
    endtask

    task automatic check_xfer(input string name, input int idx, input int owner, input int px, input int ctrl);
        if (idx >= done_log.size()) begin
            check_int({name, "_present"}, 0, 1);
        end else begin
            check_int({name, "_owner"}, done_log[idx].owner, owner);
            check_int({name, "_px"}, done_log[idx].px, px);
            check_int({name, "_ctrl"}, done_log[idx].ctrl, ctrl);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         base;
        logic [0:8] bp_px;
        logic [0:8] bp_ctrl;
        logic       r0, r1, fin;
        int         s0, s1, fo;

        bp_px   = 9'b000110000;
        bp_ctrl = 9'b010000000;

        applyStimulus(5'b10000, 0, 0);
        repeat (2) begin
            model_advance();
            @(negedge clk);
        end
        applyStimulus(5'b00000, 0, 0);
        step(1'b0, '0, "reset");
        check_vec("reset_state", last_vec_seen, '0);

        vecs[0]  = mk(5'b01000, 5, 0, 7'b0000000, 0);
        vecs[1]  = mk(5'b01000, 5, 0, 7'b1001011, 0);
        vecs[2]  = mk(5'b01000, 5, 0, 7'b1001010, 1);
        vecs[3]  = mk(5'b01000, 5, 0, 7'b1001010, 2);
        vecs[4]  = mk(5'b01000, 5, 0, 7'b1001010, 3);
        vecs[5]  = mk(5'b01000, 5, 0, 7'b1001010, 4);
        vecs[6]  = mk(5'b01000, 5, 0, 7'b1001100, 0);
        vecs[7]  = mk(5'b01100, 5, 0, 7'b0000000, 0);
        vecs[8]  = mk(5'b01100, 5, 0, 7'b0111100, 0);
        vecs[9]  = mk(5'b01000, 5, 0, 7'b0000000, 0);
        vecs[10] = mk(5'b01010, 5, 0, 7'b1001000, 0);
        vecs[11] = mk(5'b01001, 5, 0, 7'b1001000, 0);
        vecs[12] = mk(5'b01000, 5, 0, 7'b1001011, 0);
        vecs[13] = mk(5'b11000, 5, 0, 7'b1001000, 1);
        vecs[14] = mk(5'b00100, 5, 3, 7'b0000000, 0);
        vecs[15] = mk(5'b00100, 5, 3, 7'b0111011, 0);
        vecs[16] = mk(5'b00100, 5, 3, 7'b0111010, 1);
        vecs[17] = mk(5'b00100, 5, 3, 7'b0111010, 2);
        vecs[18] = mk(5'b00100, 5, 3, 7'b0111100, 0);
        vecs[19] = mk(5'b00000, 5, 3, 7'b0000000, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ctl, vecs[i].size0, vecs[i].size1);
            step(1'b1, {vecs[i].exp, SW'(vecs[i].rd)}, $sformatf("table_row%0d", i));
        end

        applyStimulus(5'b10000, 3, 4);
        step(1'b0, '0, "pre_contention_rst");
        base = done_log.size();
        applyStimulus(5'b01100, 3, 4);
        run_until_done(3, 40, "contention");
        applyStimulus(5'b00000, 3, 4);
        check_xfer("contention_first", base, 0, 3, 1);
        check_xfer("contention_second", base + 1, 1, 4, 1);
        check_xfer("contention_third", base + 2, 0, 3, 1);

        base = done_log.size();
        for (int k = 0; k < 9; k++) begin
            applyStimulus({1'b0, 1'b0, 1'b1, bp_px[k], bp_ctrl[k]}, 0, 4);
            step(1'b0, '0, "backpressure");
            if (k == 3 || k == 4) check_int("bp_stall_rd", last_rd_seen, 1);
        end
        check_xfer("backpressure", base, 1, 4, 1);

        base = done_log.size();
        applyStimulus(5'b00100, 0, 40);
        run_until_done(1, 60, "size_clamp");
        check_xfer("size_clamp", base, 1, 32, 1);
        if (base < done_log.size()) check_int("size_clamp_last_rd", done_log[base].last_rd, 31);

        base = done_log.size();
        applyStimulus(5'b01000, 0, 0);
        run_until_done(1, 10, "size_zero");
        check_xfer("size_zero", base, 0, 0, 0);

        base = done_log.size();
        applyStimulus(5'b01000, 6, 0);
        repeat (3) step(1'b0, '0, "rst_mid_run");
        applyStimulus(5'b11100, 6, 2);
        step(1'b0, '0, "rst_mid_pulse");
        check_int("rst_mid_rd_at_pulse", last_rd_seen, 2);
        applyStimulus(5'b00100, 6, 2);
        step(1'b0, '0, "rst_mid_release");
        check_vec("rst_mid_outputs", last_vec_seen, '0);
        check_int("rst_mid_no_done", done_log.size(), base);
        step(1'b0, '0, "rst_mid_grant");
        check_int("rst_mid_gnt1", int'(last_vec_seen[OUT_W-2]), 1);
        run_until_done(1, 10, "rst_mid_finish");
        check_xfer("rst_mid_req1", base, 1, 2, 1);
        applyStimulus(5'b00000, 0, 0);
        step(1'b0, '0, "pre_random");

        // requesters hold req until their done, occasionally churn size or drop early
        r0 = 1'b0;
        r1 = 1'b0;
        s0 = 0;
        s1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!r0 && $urandom_range(0, 3) == 0) begin r0 = 1'b1; s0 = rand_size(); end
            if (!r1 && $urandom_range(0, 3) == 0) begin r1 = 1'b1; s1 = rand_size(); end
            if (m_phase != M_FREE && $urandom_range(0, 7) == 0) begin
                if (m_owner == 0) s0 = rand_size(); else s1 = rand_size();
            end
            fin = (m_phase == M_FINISH);
            fo  = m_owner;
            applyStimulus({$urandom_range(0, 399) == 0, r0, r1,
                           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0}, s0, s1);
            step(1'b0, '0, "random");
            if (fin && fo == 0 && $urandom_range(0, 3) != 0) r0 = 1'b0;
            if (fin && fo == 1 && $urandom_range(0, 3) != 0) r1 = 1'b0;
            if (r0 && $urandom_range(0, 99) == 0) r0 = 1'b0;
            if (r1 && $urandom_range(0, 99) == 0) r1 = 1'b0;
        end

        applyStimulus(5'b00000, 0, 0);
        repeat (2) step(1'b0, '0, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/send_scheduler.md
SEND_SCHEDULER -- requirements
Module: send_scheduler

Interface
REQ-001 Parameter BUFF_SIZE, default 32, maximum pixels per buffer transfer.
REQ-002 Parameter BUFF_SIZE_BIT, default $clog2(BUFF_SIZE)+1, width of all size and count fields.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  send requests from requester 0 and requester 1; held high until the matching done.
REQ-006 size0, size1  input  BUFF_SIZE_BIT each  pixel count to send for each requester; sampled at grant.
REQ-007 px_full  input  1  pixel output FIFO full.
REQ-008 ctrl_full  input  1  control output FIFO full.
REQ-009 gnt0, gnt1  output  1 each  registered grant; at most one high at a time.
REQ-010 sel  output  1  data mux select; 0 = requester 0, 1 = requester 1; valid while busy.
REQ-011 rd_addr  output  BUFF_SIZE_BIT  read index into the granted buffer; equals the beat counter.
REQ-012 px_wr  output  1  pixel FIFO write strobe.
REQ-013 ctrl_wr  output  1  control FIFO write strobe (pivot, size, median position and second-median words).
REQ-014 busy  output  1  high in SEND and DONE.
REQ-015 done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-016 FSM states: IDLE, SEND, DONE; 2-bit state register.
REQ-017 IDLE: when req0|req1 is high, grant by round-robin pointer rr, which selects the preferred requester.
- If only one requester is high, it wins.
- If both are high, requester rr wins.
REQ-018 Grant cycle: latch sel, latch the clamped size, clear the counter and set the matching gnt on the same edge.
- Size clamp: min(size, BUFF_SIZE).
- Next state: SEND if the latched size is nonzero, else DONE.
REQ-019 Latency: req first sampled high in IDLE at edge t -> gnt high and busy high after edge t; first px_wr possible in that same cycle.
REQ-020 SEND beat 0 (count==0): px_wr = ctrl_wr = ~px_full & ~ctrl_full; both strobes assert together or not at all.
REQ-021 SEND beats with count>0: px_wr = ~px_full; ctrl_wr = 0.
REQ-022 Counter increments on each px_wr.
- When px_wr is high and count == size_latched-1, the next state is DONE and the counter clears.
REQ-023 Exactly size_latched px_wr pulses and exactly one ctrl_wr pulse per nonzero transfer, with no gaps other than those forced by the full flags.
REQ-024 DONE: one cycle long, with the following behaviour.
- done=1; gnt of the completed requester drops after this cycle.
- rr is set to the other requester.
- Next state is IDLE.
REQ-025 Minimum gap between transfers: one IDLE cycle after DONE; a req still high in that IDLE cycle is re-arbitrated.
REQ-026 Zero-size grant: IDLE -> DONE directly; no px_wr or ctrl_wr; done still pulses; rr still flips.
REQ-027 Requester dropping req mid-SEND is ignored; the transfer runs to completion.
REQ-028 Changes on size0/size1 after the grant do not affect the running transfer.
REQ-029 px_full or ctrl_full rising mid-beat holds count and rd_addr stable until the write succeeds.
REQ-030 px_wr and ctrl_wr are combinational from state, count and the full inputs; all other outputs are registered.

Reset
REQ-031 rst high at a clock edge forces the following values, regardless of state.
- state=IDLE, count=0, rr=0, sel=0.
- gnt0=gnt1=0, busy=0, done=0.
- px_wr=ctrl_wr=0 for the whole duration that rst is high.
REQ-032 Reset mid-transfer aborts the transfer without a done pulse; the first grant after reset release follows REQ-017 with rr=0.

Verification
REQ-033 Single transfer: req0=1, size0=5, fulls low -> gnt0 next cycle; px_wr for 5 consecutive cycles with rd_addr 0..4; ctrl_wr only at rd_addr 0; done one cycle later; rr=1.
REQ-034 Contention: req0=req1=1, size0=3, size1=4, hold both high -> order: requester 0 (3 px), then requester 1 (4 px), then requester 0; one IDLE cycle between transfers.
REQ-035 Backpressure: size1=4, px_full high for cycles 2-3 of SEND, ctrl_full high for the first cycle -> no strobes while full; exactly 4 px_wr and 1 ctrl_wr; rd_addr frozen while stalled.
REQ-036 Boundaries, two runs, each with the other request low:
- size0=0 -> done with zero writes.
- size1=40 (BUFF_SIZE=32) -> exactly 32 px_wr, last rd_addr=31.
REQ-037 Reset mid-op: rst pulsed at rd_addr=2 of a size-6 transfer -> all outputs 0 next cycle, no done; req1 pending after release is granted on the next edge.
